// File: rtl/tdm_collect8.sv
// tdm_collect8: scans the 8:1 tri-state selector slot by slot, samples the
// shared line once per slot after SETTLE wait cycles, and hands the eight
// samples to a consumer as one frame over a valid/ready pair with a sticky
// overrun flag.
module tdm_collect8 #(
    parameter int SETTLE = 1    // 0..15 wait cycles after each sel change
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       line_in,
    output logic [2:0] sel,
    output logic       en,
    output logic       busy,
    output logic [7:0] frame,
    output logic       frame_valid,
    input  logic       frame_rdy,
    output logic       ovr,
    input  logic       clr_ovr
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

    localparam int         RL     = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0] RELOAD = 4'(RL);
    // With no settle time each slot goes straight to its sample cycle
    localparam state_t     FIRST  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] asm_q;   // partial frame, bit k captured while sel==k
    logic       done;

    assign busy = (state != S_IDLE);
    assign done = (state == S_SAMPLE) && (sel == 3'd7);

    // Scan sequencer: slot select, enable, settle count, sample assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= 3'd0;
            en    <= 1'b0;
            cnt   <= 4'd0;
            asm_q <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || cont) begin
                        sel   <= 3'd0;
                        en    <= 1'b1;
                        cnt   <= RELOAD;
                        state <= FIRST;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 4'd0) state <= S_SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_SAMPLE: begin
                    asm_q[sel] <= line_in;
                    cnt        <= RELOAD;
                    if (sel != 3'd7) begin
                        sel   <= sel + 3'd1;
                        state <= FIRST;
                    end else if (cont) begin
                        // back-to-back frame: wrap without dropping en
                        sel   <= 3'd0;
                        state <= FIRST;
                    end else begin
                        sel   <= 3'd0;
                        en    <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output frame register, valid/ready handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame       <= 8'd0;
            frame_valid <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            if (done) begin
                // include the bit being captured this very cycle
                frame       <= {line_in, asm_q[6:0]};
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_rdy) begin
                frame_valid <= 1'b0;
            end
            // overwrite of an unaccepted frame; a new overrun beats the clear
            if (done && frame_valid && !frame_rdy) ovr <= 1'b1;
            else if (clr_ovr)                      ovr <= 1'b0;
        end
    end

endmodule

// File: doc/tdm_collect8.md
# tdm_collect8

Time-division collector for the 8:1 tri-state selector bus. It sits at the receiving end of the shared 1-bit line and drives that selector's `sel[2:0]` and `en`. It scans slots 0..7, samples the shared line once per slot after a programmable settle delay, and presents the eight samples as one parallel frame on a valid/ready output.

## Interface
- `SETTLE`, default 1: wait cycles after each `sel` change before sampling, legal range 0..15. It covers decoder and tri-state propagation delay.
- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin one frame scan. Sampled only in IDLE.
- `cont`, input, 1: continuous mode. While high at frame end, the next scan starts immediately.
- `line_in`, input, 1: the shared tri-state line, i.e. the selector output.
- `sel`, output, 3: slot select, driven to the selector's `sel`.
- `en`, output, 1: selector/decoder enable, high only while scanning.
- `busy`, output, 1: high in any state other than IDLE.
- `frame`, output, 8: last completed frame. `frame[k]` is the sample taken while `sel==k`.
- `frame_valid`, output, 1: `frame` holds an unconsumed frame.
- `frame_rdy`, input, 1: consumer accepts `frame` when `frame_valid && frame_rdy`.
- `ovr`, output, 1: sticky overrun flag.
- `clr_ovr`, input, 1: synchronous clear of `ovr`.

## Operation
- Reset: state IDLE; `sel`, `en`, `busy`, `frame`, `frame_valid`, `ovr` all 0; internal shift/settle counters 0. Reset asserted mid-scan aborts the scan immediately and discards the partial frame.
- States and transitions:
  - IDLE: `en=0`, `sel=0`. If `start` or `cont` is high, go to SETTLE (or SAMPLE if `SETTLE==0`), with `sel=0`, `en=1`, and settle counter loaded with `SETTLE-1`.
  - SETTLE: decrement the counter; when it is 0, go to SAMPLE.
  - SAMPLE: capture `line_in` into assembly bit `sel`.
    - If `sel<7`: increment `sel`, reload the counter, go to SETTLE (or stay in SAMPLE if `SETTLE==0`).
    - If `sel==7`: complete the frame.
- Frame completion:
  - `frame` is loaded with the assembled bits, including the bit captured that cycle, and `frame_valid` goes to 1.
  - Then, if `cont` is high, `sel` wraps to 0, `en` stays 1, and the next scan begins. Otherwise go to IDLE and drop `en`.
- `start` while `busy` is ignored. Clearing `cont` mid-scan lets the current frame finish, then the block returns to IDLE.
- `sel` and `en` are registered outputs and change only on state transitions. `sel` is stable for exactly `SETTLE+1` cycles per slot.
- Output handshake:
  - `frame_valid` clears on any cycle with `frame_valid && frame_rdy`, unless a frame completes in the same cycle.
  - Completion while `frame_valid && !frame_rdy`: the new frame overwrites `frame`, `frame_valid` stays 1, and `ovr` is set.
  - Completion in the same cycle as acceptance: the new frame loads, `frame_valid` stays 1, and there is no overrun.
- `ovr` stays set until `clr_ovr`. If `clr_ovr` coincides with a new overrun, the set wins.

## Timing
- Slot period is `SETTLE+1` cycles; frame period is `8*(SETTLE+1)` cycles. In continuous mode there is no gap between frames.
- `start` is sampled at edge E0. From the cycle after E0, `en=1` and `sel=0`.
- Slot k is sampled at edge `E0+(k+1)*(SETTLE+1)`.
- `frame_valid` is first high in the cycle after edge `E0+8*(SETTLE+1)`. With `SETTLE=1` that is 16 cycles after the `start` edge; with `SETTLE=0`, 8 cycles.
- One-shot mode: `en` and `busy` fall in the same cycle `frame_valid` rises.
- `frame` is stable while `frame_valid=1`, except on an overrun overwrite.

## Test plan
- Reset and idle: hold `rst_n=0`, then release with `start=0` → all outputs 0 indefinitely. Pulse `rst_n` low at slot 4 of a scan → `busy`, `en`, and `sel` go to 0 immediately and no `frame_valid` follows.
- One-shot, `SETTLE=1`: behavioural 8:1 selector model with inputs 8'hA5, one-cycle `start`, `frame_rdy=1` → `sel` steps 0..7 in 2 cycles each; `frame=8'hA5`; `frame_valid` high exactly 1 cycle, 16 cycles after `start`; then `busy=0`.
- `SETTLE=0` with a `cont` sweep: inputs change each frame 8'h01, 8'h80, 8'hFF, `cont=1` → back-to-back frames every 8 cycles, `sel` wraps 7→0 without `en` dropping, frames returned in order.
- Backpressure and overrun: `cont=1`, `frame_rdy=0` for two frame periods → `frame` holds the second frame and `ovr=1`. Then assert `clr_ovr` in the same cycle as a third completion → `ovr` stays 1. Assert `clr_ovr` alone → `ovr=0`.
- Simultaneous accept and complete: assert `frame_rdy` exactly on the completion cycle of the next frame → `frame_valid` stays 1, new frame loaded, `ovr=0`.
- Ignored start: pulse `start` at slot 3 of a one-shot scan → exactly one frame is produced, then IDLE.
